// File: rtl/cache_op_sched.sv
// cache_op_sched: sequences CACHE maintenance instructions from the MEM stage
// onto the dcache and icache maintenance ports. A sync request runs the dcache
// op first, then an icache hit-invalidate (5'b10000) at the same address.
// Optional build macro: CACHE_OP_SCHED_TIMEOUT_EN adds a watchdog that abandons
// a handshake after TIMEOUT cycles without ok and pulses op_timeout.
module cache_op_sched #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [4:0]  op_code,
  input  logic [31:0] op_addr,
  input  logic        op_sync,
  input  logic        op_excp,
  input  logic        flush,
  input  logic        dcache_ok,
  input  logic        icache_ok,
  output logic        busy,
  output logic        op_done,
  output logic        op_timeout,
  output logic        dcache_req,
  output logic [4:0]  dcache_op,
  output logic [31:0] dcache_addr,
  output logic        icache_req,
  output logic [4:0]  icache_op,
  output logic [31:0] icache_addr
);

  typedef enum logic [1:0] {IDLE, D_OP, I_OP, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic        sync_q, sync_d;
  logic        abort_q, abort_d;
  logic        expire;
  logic        accept;

  assign accept = op_valid && !op_excp && !flush;

`ifdef CACHE_OP_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timed_q, timed_d;

  assign expire = (cnt_q == CntW'(TIMEOUT - 1));

  // Watchdog: restarts for every handshake phase, counts cycles without ok
  always_comb begin
    cnt_d   = cnt_q;
    timed_d = timed_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        timed_d = 1'b0;
      end
      D_OP, I_OP: begin
        if ((state_q == D_OP && dcache_ok) || (state_q == I_OP && icache_ok)) begin
          cnt_d = '0;
        end else if (expire) begin
          timed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      timed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timed_q <= timed_d;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Next-state and latch logic for the scheduler
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    addr_d  = addr_q;
    sync_d  = sync_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          code_d = op_code;
          addr_d = op_addr;
          sync_d = op_sync;
          if (op_sync || op_code[1:0] == 2'b01) begin
            state_d = D_OP;
          end else if (op_code[1:0] == 2'b00) begin
            state_d = I_OP;
          end else begin
            state_d = DONE;
          end
        end
      end
      D_OP: begin
        if (flush) begin
          abort_d = 1'b1;
        end
        if (dcache_ok) begin
          state_d = (sync_q && !abort_q && !flush) ? I_OP : DONE;
        end else if (expire) begin
          state_d = DONE;
        end
      end
      I_OP: begin
        if (flush) begin
          abort_d = 1'b1;
        end
        if (icache_ok || expire) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-operation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      addr_q  <= '0;
      sync_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      sync_q  <= sync_d;
      abort_q <= abort_d;
    end
  end

  // Port decode; sync_q only reaches I_OP through D_OP, so it marks phase two
  assign busy        = (state_q != IDLE);
  assign dcache_req  = (state_q == D_OP);
  assign icache_req  = (state_q == I_OP);
  assign dcache_op   = code_q;
  assign icache_op   = sync_q ? 5'b10000 : code_q;
  assign dcache_addr = addr_q;
  assign icache_addr = addr_q;
  assign op_done     = (state_q == DONE) && !abort_q && !flush;

`ifdef CACHE_OP_SCHED_TIMEOUT_EN
  assign op_timeout  = op_done && timed_q;
`else
  assign op_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_cache_op_sched.sv
// Directed testbench for cache_op_sched. Inputs change 1ns after the rising
// edge and outputs are sampled there, away from the active edge.
module tb_cache_op_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [4:0]  op_code;
  logic [31:0] op_addr;
  logic        op_sync;
  logic        op_excp;
  logic        flush;
  logic        dcache_ok;
  logic        icache_ok;
  logic        busy;
  logic        op_done;
  logic        op_timeout;
  logic        dcache_req;
  logic [4:0]  dcache_op;
  logic [31:0] dcache_addr;
  logic        icache_req;
  logic [4:0]  icache_op;
  logic [31:0] icache_addr;

  int checks = 0;
  int errors = 0;

  cache_op_sched #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_addr(op_addr), .op_sync(op_sync), .op_excp(op_excp), .flush(flush),
    .dcache_ok(dcache_ok), .icache_ok(icache_ok), .busy(busy),
    .op_done(op_done), .op_timeout(op_timeout), .dcache_req(dcache_req),
    .dcache_op(dcache_op), .dcache_addr(dcache_addr), .icache_req(icache_req),
    .icache_op(icache_op), .icache_addr(icache_addr)
  );

  // Free-running 10ns clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] code, input logic [31:0] addr, input logic sync);
    op_valid = 1'b1;
    op_code  = code;
    op_addr  = addr;
    op_sync  = sync;
  endtask

  task automatic idle_inputs;
    op_valid  = 1'b0;
    op_code   = 5'b0;
    op_addr   = 32'h0;
    op_sync   = 1'b0;
    op_excp   = 1'b0;
    flush     = 1'b0;
    dcache_ok = 1'b0;
    icache_ok = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, op_done, op_timeout, dcache_req, icache_req} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {busy, op_done, op_timeout, dcache_req, icache_req});
    end
    checks++;
    if ({dcache_op, icache_op, dcache_addr, icache_addr} !== 74'h0) begin
      errors++;
      $display("[TB] FAIL reset_ports: got %h/%h/%h/%h expected all zero",
               dcache_op, icache_op, dcache_addr, icache_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dcache_single;
    present(5'b00001, 32'h8000_1000, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if ({dcache_req, icache_req, busy, op_done} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL dc_req_cycle: got req/ireq/busy/done %b expected 1010",
               {dcache_req, icache_req, busy, op_done});
    end
    checks++;
    if (dcache_addr !== 32'h8000_1000 || dcache_op !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL dc_addr_op: got %h/%b expected 80001000/00001", dcache_addr, dcache_op);
    end
    dcache_ok = 1'b1;
    tick();
    dcache_ok = 1'b0;
    checks++;
    if ({dcache_req, busy, op_done} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL dc_done: got req/busy/done %b expected 011", {dcache_req, busy, op_done});
    end
    tick();
    checks++;
    if ({busy, op_done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL dc_idle: got busy/done %b expected 00", {busy, op_done});
    end
  endtask

  task automatic test_sync_sequence;
    int doneCount = 0;
    present(5'b10101, 32'h8000_2040, 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dcache_req !== 1'b1 || icache_req !== 1'b0 || dcache_op !== 5'b10101) begin
        errors++;
        $display("[TB] FAIL sync_dreq[%0d]: got dreq/ireq/op %b/%b/%b expected 1/0/10101",
                 i, dcache_req, icache_req, dcache_op);
      end
      if (op_done === 1'b1) doneCount++;
      dcache_ok = (i == 3);
      tick();
    end
    dcache_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (icache_req !== 1'b1 || dcache_req !== 1'b0 || icache_op !== 5'b10000
          || icache_addr !== 32'h8000_2040) begin
        errors++;
        $display("[TB] FAIL sync_ireq[%0d]: got ireq/dreq/op/addr %b/%b/%b/%h expected 1/0/10000/80002040",
                 i, icache_req, dcache_req, icache_op, icache_addr);
      end
      if (op_done === 1'b1) doneCount++;
      icache_ok = (i == 1);
      tick();
    end
    icache_ok = 1'b0;
    if (op_done === 1'b1) doneCount++;
    tick();
    if (op_done === 1'b1) doneCount++;
    checks++;
    if (doneCount != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sync_done_count: got %0d pulses busy %b expected 1 pulses busy 0",
               doneCount, busy);
    end
  endtask

  task automatic test_no_action_and_excp;
    present(5'b00010, 32'h0000_0100, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if ({dcache_req, icache_req, op_done, busy} !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL noact_done: got dreq/ireq/done/busy %b expected 0011",
               {dcache_req, icache_req, op_done, busy});
    end
    tick();
    present(5'b00000, 32'h0000_0200, 1'b0);
    op_excp = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({dcache_req, icache_req, op_done, busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL excp_ignored: got dreq/ireq/done/busy %b expected 0000",
               {dcache_req, icache_req, op_done, busy});
    end
    present(5'b00001, 32'h0000_0300, 1'b0);
    flush = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({dcache_req, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL flush_idle_ignored: got dreq/busy %b expected 00", {dcache_req, busy});
    end
  endtask

  task automatic test_flush_abort;
    present(5'b00001, 32'h0000_4000, 1'b1);
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dcache_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_hold_req: got %b expected 1", dcache_req);
    end
    tick();
    dcache_ok = 1'b1;
    tick();
    dcache_ok = 1'b0;
    checks++;
    if ({icache_req, op_done, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL abort_done: got ireq/done/busy %b expected 001", {icache_req, op_done, busy});
    end
    tick();
    checks++;
    if ({icache_req, op_done, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_idle: got ireq/done/busy %b expected 000", {icache_req, op_done, busy});
    end
    present(5'b00011, 32'h0, 1'b0);
    tick();
    idle_inputs();
    flush = 1'b1;
    #1;
    checks++;
    if (op_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_in_done: got done/busy %b%b expected 01", op_done, busy);
    end
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_handshake;
    present(5'b00000, 32'h0000_5000, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (icache_req !== 1'b1 || icache_op !== 5'b00000 || icache_addr !== 32'h0000_5000) begin
      errors++;
      $display("[TB] FAIL ic_req: got req/op/addr %b/%b/%h expected 1/00000/00005000",
               icache_req, icache_op, icache_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({icache_req, busy} !== 2'b00 || icache_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid: got ireq/busy %b addr %h expected 00 addr 0",
               {icache_req, busy}, icache_addr);
    end
    present(5'b01001, 32'h0000_6000, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (dcache_req !== 1'b1 || dcache_addr !== 32'h0000_6000) begin
      errors++;
      $display("[TB] FAIL post_rst_accept: got req/addr %b/%h expected 1/00006000", dcache_req, dcache_addr);
    end
    dcache_ok = 1'b1;
    tick();
    dcache_ok = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int reqCycles = 0;
    present(5'b00001, 32'h0000_7000, 1'b0);
    tick();
    idle_inputs();
`ifdef CACHE_OP_SCHED_TIMEOUT_EN
    for (int i = 0; i < 12 && dcache_req === 1'b1; i++) begin
      reqCycles++;
      tick();
    end
    checks++;
    if (reqCycles != 8 || op_done !== 1'b1 || op_timeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got %0d req cycles done/timeout %b%b expected 8 and 11",
               reqCycles, op_done, op_timeout);
    end
    tick();
    checks++;
    if ({busy, op_timeout} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL timeout_idle: got busy/timeout %b expected 00", {busy, op_timeout});
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (dcache_req === 1'b1 && op_timeout === 1'b0) reqCycles++;
      tick();
    end
    checks++;
    if (reqCycles != 20 || dcache_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_timeout_wait: got %0d held cycles req %b expected 20 and 1",
               reqCycles, dcache_req);
    end
    dcache_ok = 1'b1;
    tick();
    dcache_ok = 1'b0;
    checks++;
    if (op_done !== 1'b1 || op_timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_ok_done: got done/timeout %b%b expected 10", op_done, op_timeout);
    end
    tick();
`endif
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_dcache_single();
    test_sync_sequence();
    test_no_action_and_excp();
    test_flush_abort();
    test_reset_mid_handshake();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
